io_port_ctrl: RTL and testbench
===============================

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the number of consecutive stable synchronised samples required to accept a level change; legal range 2..65535.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the debounce counter; CNT_W SHALL satisfy 2**CNT_W > DEBOUNCE_CYCLES.
REQ-003 SHALL have port clk  input  1  single system clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port btn_raw  input  4  asynchronous push-button pins.
REQ-006 SHALL have port in_port  output  4  debounced button levels, fed to the control unit's in_port.
REQ-007 SHALL have port out_port  input  4  LED value driven by the control unit.
REQ-008 SHALL have port led  output  4  registered LED pin drive.
REQ-009 SHALL have port btn_evt  output  4  sticky per-button rising-edge flags.
REQ-010 SHALL have port evt_clr  input  4  per-bit, one-cycle clear strobes for btn_evt.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchroniser before any other logic uses it.
REQ-012 Each bit SHALL run an independent 4-state FSM: ST_LO, PEND_HI, ST_HI, PEND_LO.
REQ-013 In ST_LO, sync=1 SHALL cause a transition to PEND_HI with cnt<=0; in ST_HI, sync=0 SHALL cause a transition to PEND_LO with cnt<=0.
REQ-014 In PEND_HI, sync=0 SHALL return the FSM to ST_LO; when sync=1 and cnt==DEBOUNCE_CYCLES-1 the FSM SHALL enter ST_HI; otherwise cnt SHALL increment. PEND_LO SHALL behave symmetrically.
REQ-015 in_port[i] SHALL be 1 exactly when FSM i is in ST_HI or PEND_LO.
REQ-016 Latency: a clean raw change sampled at edge k SHALL become visible on in_port after edge k+DEBOUNCE_CYCLES+2.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES synchronised samples SHALL NOT change in_port and SHALL NOT set btn_evt.
REQ-018 The counter SHALL never wrap; it SHALL be reset on every entry to a PEND state.
REQ-019 led SHALL equal out_port registered, with a latency of 1 cycle.

Reset
REQ-020 While reset=0, the synchronisers, in_port, btn_evt and led SHALL be 0, all FSMs SHALL be in ST_LO, and all counters SHALL be 0, independent of clk.
REQ-021 Reset asserted during a PEND state SHALL abort the count with no event generated; after release, a held button SHALL be re-debounced from ST_LO and SHALL then produce one btn_evt.

Configuration
REQ-022 Macro IO_EDGE_LATCH_EN defined: a ST_LO/PEND_HI->ST_HI transition SHALL set btn_evt[i] at the same edge in_port[i] rises; evt_clr[i]=1 SHALL clear it; a simultaneous set and clear SHALL leave the flag set.
REQ-023 Macro IO_EDGE_LATCH_EN undefined: btn_evt SHALL be constant 0 and evt_clr SHALL be ignored, with no flag registers synthesised.

Structure
REQ-024 Package io_pkg SHALL hold the debounce state enum typedef (ST_LO, PEND_HI, ST_HI, PEND_LO) and the default DEBOUNCE_CYCLES constant.
REQ-025 Sub-module io_debounce SHALL implement one bit (synchroniser, FSM, counter, rise pulse) and SHALL be instantiated 4 times via a generate loop; the top SHALL hold the led register and the edge latches.

Verification (DEBOUNCE_CYCLES=16)
REQ-026 Reset: reset=0 with btn_raw=4'hF, out_port=4'hA -> in_port=0, led=0, btn_evt=0; within 2 cycles after release -> led=4'hA.
REQ-027 Clean press: btn_raw[0] 0->1 held, sampled at edge k -> in_port=4'h1 after edge k+18 and not before; btn_evt[0]=1 from the same edge.
REQ-028 Bounce: btn_raw[1] toggled every 5 cycles for 60 cycles, then held 1 -> in_port[1] rises exactly 18 edges after the last toggle; btn_evt[1] is set exactly once.
REQ-029 Release: btn_raw[2] 1->0 after a debounced press -> in_port[2] falls after 18 edges; btn_evt unchanged.
REQ-030 Clear race: evt_clr[3]=1 on the same edge btn_evt[3] would be set -> btn_evt[3]=1; evt_clr[3]=1 on the next cycle -> btn_evt[3]=0.
REQ-031 Mid-operation reset: reset=0 asserted for 1 cycle while btn_raw[0] has been held high for 10 cycles -> no event during reset; btn_evt[0] is set 18 edges after reset release.

Source files
------------

// File: rtl/io_pkg.sv
// Shared types and defaults for the push-button / LED I/O port controller.
package io_pkg;

    localparam int DEBOUNCE_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        PEND_HI = 2'd1,
        ST_HI   = 2'd2,
        PEND_LO = 2'd3
    } db_state_t;

endpackage

// File: rtl/io_debounce.sv
// One debounced input bit: 2-flop synchroniser, 4-state debounce FSM with a
// saturating-free counter, and a one-cycle pulse on the accepted low-to-high change.
module io_debounce
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    db_state_t        state;
    db_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_LO;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The count stops at CNT_LAST by leaving the PEND state, so it never wraps.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rise       = 1'b0;
        case (state)
            ST_LO: begin
                if (sync_b) begin
                    state_next = PEND_HI;
                    cnt_next   = '0;
                end
            end
            PEND_HI: begin
                if (!sync_b) begin
                    state_next = ST_LO;
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_HI;
                    rise       = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_HI: begin
                if (!sync_b) begin
                    state_next = PEND_LO;
                    cnt_next   = '0;
                end
            end
            PEND_LO: begin
                if (sync_b) begin
                    state_next = ST_HI;
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_LO;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_LO;
                cnt_next   = '0;
            end
        endcase
    end

    // A pending release still reports the button as pressed.
    assign level = (state == ST_HI) || (state == PEND_LO);

endmodule

// File: rtl/io_port_ctrl.sv
// I/O port controller: four debounced buttons, registered LED drive and
// optional sticky rising-edge flags (enabled by defining IO_EDGE_LATCH_EN).
module io_port_ctrl
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    output logic [3:0] in_port,
    input  logic [3:0] out_port,
    output logic [3:0] led,
    output logic [3:0] btn_evt,
    input  logic [3:0] evt_clr
);

    logic [3:0] rise;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[i]),
            .level(in_port[i]),
            .rise (rise[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led <= '0;
        end else begin
            led <= out_port;
        end
    end

`ifdef IO_EDGE_LATCH_EN
    logic [3:0] evt_q;

    // A new edge wins over a clear arriving on the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt_q <= '0;
        end else begin
            evt_q <= (evt_q & ~evt_clr) | rise;
        end
    end

    assign btn_evt = evt_q;
`else
    logic unused_evt;

    assign unused_evt = ^{evt_clr, rise};
    assign btn_evt    = '0;
`endif

endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: directed scenarios plus randomized traffic, all
// compared every cycle against a run-length model of the debounce rules.
module tb_io_port_ctrl;

    localparam int D = 16;
`ifdef IO_EDGE_LATCH_EN
    localparam bit EVT_EN = 1'b1;
`else
    localparam bit EVT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] in_port;
    logic [3:0] out_port;
    logic [3:0] led;
    logic [3:0] btn_evt;
    logic [3:0] evt_clr;

    int errors = 0;
    int checks = 0;

    // Reference model: raw delayed two edges, accepted level, run length of
    // samples disagreeing with the level, sticky flags and LED copy.
    logic [3:0] d1, d2, lvl_m, evt_m, led_m;
    int         run [4];

    io_port_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .in_port (in_port),
        .out_port(out_port),
        .led     (led),
        .btn_evt (btn_evt),
        .evt_clr (evt_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        d1 = '0; d2 = '0; lvl_m = '0; evt_m = '0; led_m = '0;
        for (int i = 0; i < 4; i++) run[i] = 0;
    endtask

    // A level flips once D+1 consecutive synchronised samples disagree with it.
    task automatic model_edge();
        logic [3:0] rise_m;
        rise_m = '0;
        for (int i = 0; i < 4; i++) begin
            if (d2[i] != lvl_m[i]) begin
                run[i]++;
                if (run[i] == D + 1) begin
                    lvl_m[i]  = d2[i];
                    run[i]    = 0;
                    rise_m[i] = d2[i];
                end
            end else begin
                run[i] = 0;
            end
        end
        evt_m = EVT_EN ? ((evt_m & ~evt_clr) | rise_m) : 4'h0;
        d2    = d1;
        d1    = btn_raw;
        led_m = out_port;
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".in_port"}, in_port, lvl_m);
        check({ctx, ".led"}, led, led_m);
        check({ctx, ".btn_evt"}, btn_evt, evt_m);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Called away from a clock edge; releases reset away from an edge too.
    task automatic apply_reset(input int cycles);
        reset = 1'b0;
        model_reset();
        #2;
        check({"rst.in_port"}, in_port, 4'h0);
        check({"rst.led"}, led, 4'h0);
        check({"rst.btn_evt"}, btn_evt, 4'h0);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            check_all("rst_hold");
        end
        reset = 1'b1;
    endtask

    initial begin
        int         rises;
        logic       prev;
        logic [3:0] saved;
        int         hold [4];

        btn_raw  = 4'hF;
        out_port = 4'hA;
        evt_clr  = 4'h0;
        model_reset();

        // Reset with all buttons pressed and an LED pattern presented.
        apply_reset(3);
        step();
        check("r026_led", led, 4'hA);
        btn_raw = 4'h0;
        steps(24);

        // Clean press on bit 0.
        apply_reset(1);
        btn_raw = 4'h1;
        steps(D + 2);
        check("r027_early_in", in_port, 4'h0);
        check("r027_early_evt", btn_evt, 4'h0);
        step();
        check("r027_in", in_port, 4'h1);
        check("r027_evt", btn_evt, {3'b000, EVT_EN});

        // Bouncing bit 1, then held.
        apply_reset(1);
        btn_raw = 4'h0;
        rises = 0;
        prev  = 1'b0;
        for (int t = 0; t < 12; t++) begin
            btn_raw[1] = ~btn_raw[1];
            for (int k = 0; k < 5; k++) begin
                step();
                if (btn_evt[1] && !prev) rises++;
                prev = btn_evt[1];
            end
        end
        check("r028_bounce_in", in_port, 4'h0);
        btn_raw[1] = 1'b1;
        for (int k = 0; k < D + 2; k++) begin
            step();
            if (btn_evt[1] && !prev) rises++;
            prev = btn_evt[1];
        end
        check("r028_early_in", in_port, 4'h0);
        for (int k = 0; k < 10; k++) begin
            step();
            if (btn_evt[1] && !prev) rises++;
            prev = btn_evt[1];
        end
        check("r028_in", in_port, 4'h2);
        check("r028_evt_count", 4'(rises), 4'(EVT_EN ? 1 : 0));

        // Release of bit 2 after a debounced press.
        apply_reset(1);
        btn_raw = 4'h4;
        steps(25);
        saved = btn_evt;
        btn_raw = 4'h0;
        steps(D + 2);
        check("r029_still_hi", in_port, 4'h4);
        step();
        check("r029_in", in_port, 4'h0);
        check("r029_evt", btn_evt, saved);

        // Clear arriving on the setting edge, then on the next one.
        apply_reset(1);
        btn_raw = 4'h8;
        steps(D + 2);
        evt_clr = 4'h8;
        step();
        check("r030_race", btn_evt, {EVT_EN, 3'b000});
        step();
        evt_clr = 4'h0;
        check("r030_clr", btn_evt, 4'h0);

        // Reset in the middle of a pending press.
        apply_reset(1);
        btn_raw = 4'h1;
        steps(10);
        apply_reset(1);
        steps(D + 2);
        check("r031_pre", btn_evt, 4'h0);
        step();
        check("r031_evt", btn_evt, {3'b000, EVT_EN});
        check("r031_in", in_port, 4'h1);

        // Randomized traffic: mixed glitches and long holds per bit.
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    hold[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14))
                                                          : int'($urandom_range(15, 40));
                end else begin
                    hold[i]--;
                end
                evt_clr[i] = ($urandom_range(0, 7) == 0);
            end
            out_port = 4'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                apply_reset(1);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
